pipe_exe_muldiv: RTL and testbench
==================================

# pipe_exe_muldiv

Multi-cycle multiply/divide unit in the EXE stage. It consumes the operand and opcode fields registered by the ID/EXE pipeline register and owns the architectural HI/LO registers. While an operation is in flight it raises `Stall` so the hazard logic freezes the front of the pipeline. Iterative shift-add multiply and restoring divide, 32 iterations each.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI and LO width. Iteration count equals `WIDTH`.

Ports:
- `Clk`  in  1  clock, rising edge.
- `Clrn`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  launch an operation using `Mdop`, `E_qa`, `E_qb`.
- `Mdop`  in  2  00 mult, 01 multu, 10 div, 11 divu.
- `E_qa`  in  WIDTH  operand A (multiplicand/dividend); also the mthi/mtlo data.
- `E_qb`  in  WIDTH  operand B (multiplier/divisor).
- `Mthi`  in  1  write `E_qa` into HI.
- `Mtlo`  in  1  write `E_qa` into LO.
- `Flush`  in  1  abort any in-flight operation.
- `Busy`  out  1  operation in flight (registered state).
- `Stall`  out  1  `Busy | Start`, combinational.
- `Done`  out  1  one-cycle pulse when HI/LO have been updated by a completed op.
- `Hi`  out  WIDTH  HI register.
- `Lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, BUSY. Reset to IDLE; `Hi`=0, `Lo`=0, `Busy`=0, `Done`=0, iteration counter=0.
- IDLE with `Start`=1 and `Flush`=0: latch operands; for signed ops latch magnitudes plus result-sign flags; counter=0; go to BUSY.
- BUSY: one iteration per cycle. Multiply: 2·WIDTH-bit shift-add. Divide: restoring subtract-shift. After iteration WIDTH-1, apply sign correction, write HI/LO, return to IDLE, pulse `Done`.
- Results:
  - mult/multu: {Hi,Lo} = full 2·WIDTH-bit product, two's complement for mult.
  - div/divu: Lo = quotient, Hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (`E_qb`=0), both signed and unsigned: Lo = all ones, Hi = dividend as latched (`E_qa`). Takes the full iteration count.
- Signed overflow (div, A = most-negative, B = −1): Lo = 32'h80000000, Hi = 0.
- `Mthi`/`Mtlo` take effect only in IDLE with `Start`=0; both may be set in the same cycle. They are ignored in BUSY, and `Start` wins over them.
- `Start` in BUSY is ignored; `Stall` stays high regardless.
- `Flush` in BUSY: go to IDLE next edge; HI/LO unchanged; no `Done`. `Flush` with `Start` in IDLE: nothing is launched.
- Async reset mid-operation: immediate IDLE, HI/LO cleared, no `Done`.

## Timing
- `Start` sampled at edge T0. `Busy`=1 after T0 through edge T0+WIDTH.
- HI/LO update at edge T0+WIDTH; `Done`=1 for the cycle following that edge.
- `Busy` falls at that same edge.
- Latency: WIDTH cycles from accept to result visible.
- A new `Start` may be accepted in the cycle `Done` is high (back-to-back, no bubble).
- Reading `Hi`/`Lo` in the `Done` cycle returns the new result.
- Mthi/Mtlo: the written value is visible on the next cycle.

## Configuration
- `MULDIV_FAST_MULT_EN` defined: mult/multu complete in a single cycle using a combinational WIDTH×WIDTH multiplier.
  - `Busy` is high for one cycle, and results are written at T0+1.
  - `Done` pulses the cycle after that.
  - Divide is unchanged.
- Not defined: multiply uses the iterative WIDTH-cycle datapath; no hardware multiplier is inferred.

## Test plan
- Reset, then multu A=32'hFFFFFFFF, B=2:
  - Busy for 32 cycles, then Hi=1, Lo=32'hFFFFFFFE, one Done pulse.
  - With `MULDIV_FAST_MULT_EN`: same result after 1 cycle.
- mult A=−7, B=3 → Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB.
- div A=−7, B=2 → Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF.
- Divide by zero: divu A=100, B=0 → Lo=32'hFFFFFFFF, Hi=100.
- Signed overflow: div A=32'h80000000, B=32'hFFFFFFFF → Lo=32'h80000000, Hi=0.
- Sequencing and control:
  - Start divu 100/7; assert Flush at cycle 10 → Busy drops next edge, HI/LO keep prior values, no Done.
  - Issue divu 100/7 with Start asserted again in the Done cycle → back-to-back accept.
  - Mthi 5 issued while BUSY → ignored.
  - Mtlo 9 in IDLE → Lo=9 next cycle.

Source files
------------

// File: rtl/pipe_exe_muldiv.sv
// pipe_exe_muldiv: iterative EXE-stage multiply/divide unit owning HI/LO; stalls the pipe while busy.
// Define MULDIV_FAST_MULT_EN for single-cycle multiply through a combinational multiplier.
module pipe_exe_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             Start,
    input  logic [1:0]       Mdop,
    input  logic [WIDTH-1:0] E_qa,
    input  logic [WIDTH-1:0] E_qb,
    input  logic             Mthi,
    input  logic             Mtlo,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 div_q, qneg_q, rneg_q, dz_q, done_q;
    logic [WIDTH-1:0]     m_q, a_q, hi_q, lo_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d, mul_d, div_d, prod;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     a_mag, b_mag, quo, rem, hi_d, lo_d;
    logic                 a_neg, b_neg, last;
    assign a_neg = ~Mdop[0] & E_qa[WIDTH-1];
    assign b_neg = ~Mdop[0] & E_qb[WIDTH-1];
    assign a_mag = a_neg ? -E_qa : E_qa;
    assign b_mag = b_neg ? -E_qb : E_qb;
`ifdef MULDIV_FAST_MULT_EN
    assign mul_d = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
    assign last  = !div_q || cnt_q == CW'(WIDTH - 1);
`else
    logic [WIDTH:0] sum;
    // acc holds {partial product, remaining multiplier bits}, shifted right each step
    assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? m_q : {WIDTH{1'b0}}};
    assign mul_d = {sum, acc_q[WIDTH-1:1]};
    assign last  = cnt_q == CW'(WIDTH - 1);
`endif
    // acc holds {partial remainder, remaining dividend bits / quotient bits}
    assign diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
    assign div_d = diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign acc_d = div_q ? div_d : mul_d;
    assign prod  = qneg_q ? -acc_d : acc_d;
    assign quo   = acc_d[WIDTH-1:0];
    assign rem   = acc_d[2*WIDTH-1:WIDTH];
    assign hi_d  = !div_q ? prod[2*WIDTH-1:WIDTH] : dz_q ? a_q : rneg_q ? -rem : rem;
    assign lo_d  = !div_q ? prod[WIDTH-1:0] : dz_q ? {WIDTH{1'b1}} : qneg_q ? -quo : quo;
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            m_q     <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (Start && !Flush) begin
                    state_q <= BUSY;
                    cnt_q   <= '0;
                    div_q   <= Mdop[1];
                    qneg_q  <= a_neg ^ b_neg;
                    rneg_q  <= a_neg;
                    dz_q    <= E_qb == '0;
                    a_q     <= E_qa;
                    m_q     <= Mdop[1] ? b_mag : a_mag;
                    acc_q   <= {{WIDTH{1'b0}}, Mdop[1] ? a_mag : b_mag};
                end else if (!Start) begin
                    if (Mthi) hi_q <= E_qa;
                    if (Mtlo) lo_q <= E_qa;
                end
            end else if (Flush) begin
                state_q <= IDLE;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + 1'b1;
                if (last) begin
                    state_q <= IDLE;
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                end
            end
        end
    end
    assign Busy  = state_q == BUSY;
    assign Stall = Busy | Start;
    assign Done  = done_q;
    assign Hi    = hi_q;
    assign Lo    = lo_q;
endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// tb_pipe_exe_muldiv: directed-vector bench for pipe_exe_muldiv.
module tb_pipe_exe_muldiv;
    localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MLAT = 1;
`else
    localparam int MLAT = W;
`endif
    logic         Clk = 1'b0, Clrn = 1'b0, Start = 1'b0, Mthi = 1'b0, Mtlo = 1'b0, Flush = 1'b0;
    logic [1:0]   Mdop = 2'b00;
    logic [W-1:0] E_qa = '0, E_qb = '0;
    logic         Busy, Stall, Done;
    logic [W-1:0] Hi, Lo;
    int checks = 0, failures = 0;
    pipe_exe_muldiv #(.WIDTH(W)) dut (
        .Clk(Clk), .Clrn(Clrn), .Start(Start), .Mdop(Mdop), .E_qa(E_qa), .E_qb(E_qb),
        .Mthi(Mthi), .Mtlo(Mtlo), .Flush(Flush), .Busy(Busy), .Stall(Stall), .Done(Done),
        .Hi(Hi), .Lo(Lo)
    );
    always #5 Clk = ~Clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        Start = 1'b1; Mdop = op; E_qa = a; E_qb = b;
        @(negedge Clk);
        Start = 1'b0; E_qa = '0; E_qb = '0;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (!Done && n < 100) begin
            @(negedge Clk);
            n++;
        end
    endtask
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int lat);
        int n;
        launch(op, a, b);
        check({tag, ".busy"}, 64'(Busy), 64'd1);
        check({tag, ".stall"}, 64'(Stall), 64'd1);
        wait_done(n);
        check({tag, ".lat"}, 64'(n), 64'(lat));
        check({tag, ".hi"}, 64'(Hi), 64'(eh));
        check({tag, ".lo"}, 64'(Lo), 64'(el));
        check({tag, ".idle"}, 64'(Busy), 64'd0);
        @(negedge Clk);
        check({tag, ".done_pulse"}, 64'(Done), 64'd0);
    endtask
    initial begin
        int n, dn;
        repeat (2) @(negedge Clk);
        check("rst.hi", 64'(Hi), 64'd0);
        check("rst.lo", 64'(Lo), 64'd0);
        check("rst.busy", 64'(Busy), 64'd0);
        check("rst.done", 64'(Done), 64'd0);
        check("rst.stall", 64'(Stall), 64'd0);
        Clrn = 1'b1;
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, MLAT);
        run_op("mult_neg", 2'b00, -32'sd7, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, MLAT);
        run_op("div_neg", 2'b10, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, W);
        run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, W);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, W);
        run_op("div_zero_s", 2'b10, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, W);
        run_op("divu_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, W);
        // Mthi while busy must not disturb the product
        launch(2'b01, 32'd3, 32'd4);
        repeat (3) @(negedge Clk);
        Mthi = 1'b1; E_qa = 32'd5;
        @(negedge Clk);
        Mthi = 1'b0; E_qa = '0;
        wait_done(n);
        check("mthi_busy.hi", 64'(Hi), 64'd0);
        check("mthi_busy.lo", 64'(Lo), 64'd12);
        @(negedge Clk);
        Mtlo = 1'b1; E_qa = 32'd9;
        @(negedge Clk);
        Mtlo = 1'b0; E_qa = '0;
        check("mtlo.lo", 64'(Lo), 64'd9);
        check("mtlo.hi", 64'(Hi), 64'd0);
        Mthi = 1'b1; Mtlo = 1'b1; E_qa = 32'd77;
        @(negedge Clk);
        Mthi = 1'b0; Mtlo = 1'b0; E_qa = '0;
        check("mthilo.hi", 64'(Hi), 64'd77);
        check("mthilo.lo", 64'(Lo), 64'd77);
        launch(2'b11, 32'd100, 32'd7);
        repeat (8) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush.busy", 64'(Busy), 64'd0);
        check("flush.hi", 64'(Hi), 64'd77);
        check("flush.lo", 64'(Lo), 64'd77);
        dn = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) dn++;
        end
        check("flush.no_done", 64'(dn), 64'd0);
        check("flush.lo_kept", 64'(Lo), 64'd77);
        Start = 1'b1; Flush = 1'b1; Mdop = 2'b11; E_qa = 32'd100; E_qb = 32'd7;
        @(negedge Clk);
        Start = 1'b0; Flush = 1'b0;
        check("flush_start.busy", 64'(Busy), 64'd0);
        launch(2'b11, 32'd100, 32'd7);
        wait_done(n);
        check("b2b.first_lo", 64'(Lo), 64'd14);
        check("b2b.first_hi", 64'(Hi), 64'd2);
        Start = 1'b1; Mdop = 2'b11; E_qa = 32'd200; E_qb = 32'd7;
        @(negedge Clk);
        Start = 1'b0;
        check("b2b.accept", 64'(Busy), 64'd1);
        wait_done(n);
        check("b2b.lat", 64'(n), 64'(W));
        check("b2b.lo", 64'(Lo), 64'd28);
        check("b2b.hi", 64'(Hi), 64'd4);
        launch(2'b11, 32'd100, 32'd7);
        repeat (3) @(negedge Clk);
        #2 Clrn = 1'b0;
        #1;
        check("arst.busy", 64'(Busy), 64'd0);
        check("arst.hi", 64'(Hi), 64'd0);
        check("arst.lo", 64'(Lo), 64'd0);
        @(negedge Clk);
        Clrn = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) dn++;
        end
        check("arst.no_done", 64'(dn), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
